// File: rtl/pat5b3_drv.sv
// Registered burst driver for a NAND5B3-style detector: drives MATCH_PAT for LEN
// cycles, repeats REP more times separated by GAP_CYCLES idle cycles, then pulses DONE.
module pat5b3_drv #(
    parameter int           LEN_W      = 4,
    parameter int           GAP_CYCLES = 1,
    parameter logic [4:0]   IDLE_PAT   = 5'b00111,
    parameter logic [4:0]   MATCH_PAT  = 5'b11000
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic [3:0]       REP,
    output logic [4:0]       O,
    output logic             BUSY,
    output logic             DONE
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_lat_q, len_lat_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic [3:0]         rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [4:0]         o_d;
    logic               busy_d;
    logic               done_d;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            len_lat_q <= '0;
            len_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            O         <= IDLE_PAT;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            len_lat_q <= len_lat_d;
            len_cnt_q <= len_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            O         <= o_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
        end
    end

    // Outputs are computed here as next-values so O/BUSY/DONE leave the flops directly.
    always_comb begin
        state_d   = state_q;
        len_lat_d = len_lat_q;
        len_cnt_d = len_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        o_d       = O;
        busy_d    = BUSY;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    len_lat_d = LEN;
                    rep_cnt_d = REP;
                    if (LEN == '0) begin
                        o_d    = IDLE_PAT;
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_ASSERT;
                        o_d       = MATCH_PAT;
                        busy_d    = 1'b1;
                        len_cnt_d = LEN - LEN_W'(1);
                    end
                end
            end

            S_ASSERT: begin
                o_d = MATCH_PAT;
                if (len_cnt_q == '0) begin
                    o_d = IDLE_PAT;
                    if (rep_cnt_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        rep_cnt_d = rep_cnt_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end

            S_GAP: begin
                o_d = IDLE_PAT;
                if (gap_cnt_q == '0) begin
                    state_d   = S_ASSERT;
                    o_d       = MATCH_PAT;
                    len_cnt_d = len_lat_q - LEN_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                o_d     = IDLE_PAT;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
